// File: rtl/bus_decode_ctrl_if.sv
// CPU-side bus bundle for bus_decode_ctrl: multiplexed address/data, strobes, and the
// decoded chip selects, READY and error flag returned to the CPU.
interface bus_decode_ctrl_if;
    logic        ale;
    logic        rd_n;
    logic        wr_n;
    logic        iom;
    logic [11:0] a;
    logic [7:0]  ad;
    logic [19:0] address;
    logic        cs_mem0;
    logic        cs_mem1;
    logic        cs_io0;
    logic        cs_io1;
    logic        ready;
    logic        bus_err;

    modport master (
        output ale, rd_n, wr_n, iom, a, ad,
        input  address, cs_mem0, cs_mem1, cs_io0, cs_io1, ready, bus_err
    );

    modport slave (
        input  ale, rd_n, wr_n, iom, a, ad,
        output address, cs_mem0, cs_mem1, cs_io0, cs_io1, ready, bus_err
    );
endinterface

// File: rtl/bus_decode_ctrl.sv
// Address latch, chip-select decode and wait-state sequencer for a multiplexed CPU bus.
// Optional sticky error flag is compiled in when BUS_DECODE_ERR_EN is defined.
//
// state  | meaning
// IDLE   | no cycle in progress, CS only shown while ALE is high
// ADDR   | address latched, waiting for a single RD or WR strobe
// WAIT   | wait states being inserted, READY low
// XFER   | data transfer, READY high until both strobes release
module bus_decode_ctrl #(
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned IO_WAIT  = 2,
    parameter logic [15:0] IO0_BASE = 16'h1C00,
    parameter logic [15:0] IO1_BASE = 16'hFF00
) (
    input  logic             i_clk,
    input  logic             i_rst,
    bus_decode_ctrl_if.slave io_bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_WAIT = 2'd2,
        S_XFER = 2'd3
    } state_t;

    localparam logic [3:0] MEM_WAIT_C = 4'(MEM_WAIT);
    localparam logic [3:0] IO_WAIT_C  = 4'(IO_WAIT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [19:0] r_addr;
    logic        r_iom;

    logic        w_ale;
    logic        w_rd;
    logic        w_wr;
    logic        w_one_strobe;
    logic [19:0] w_addr;
    logic        w_iom;
    logic        w_sel_mem0;
    logic        w_sel_mem1;
    logic        w_sel_io0;
    logic        w_sel_io1;
    logic [3:0]  w_wait_load;
    logic        w_cs_en;

    // ALE is masked during reset so the outputs read as cleared immediately
    assign w_ale        = io_bus.ale & ~i_rst;
    assign w_rd         = ~io_bus.rd_n;
    assign w_wr         = ~io_bus.wr_n;
    assign w_one_strobe = w_rd ^ w_wr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr <= 20'h0;
            r_iom  <= 1'b0;
        end else if (w_ale) begin
            r_addr <= {io_bus.a, io_bus.ad};
            r_iom  <= io_bus.iom;
        end
    end

    assign w_addr      = w_ale ? {io_bus.a, io_bus.ad} : r_addr;
    assign w_iom       = w_ale ? io_bus.iom : r_iom;
    assign w_wait_load = w_iom ? IO_WAIT_C : MEM_WAIT_C;

    always_comb begin
        w_sel_mem0 = 1'b0;
        w_sel_mem1 = 1'b0;
        w_sel_io0  = 1'b0;
        w_sel_io1  = 1'b0;
        if (!w_iom) begin
            w_sel_mem0 = ~w_addr[19];
            w_sel_mem1 = w_addr[19];
        end else begin
            w_sel_io0 = (w_addr[15:4] == IO0_BASE[15:4]);
            // region 0 wins if both bases were configured equal, keeping selects one-hot
            w_sel_io1 = (w_addr[15:4] == IO1_BASE[15:4]) & ~w_sel_io0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_ale) begin
            w_state_nxt = S_ADDR;
            w_cnt_nxt   = 4'd0;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_IDLE;
                S_ADDR: begin
                    if (w_one_strobe) begin
                        w_cnt_nxt   = w_wait_load;
                        w_state_nxt = (w_wait_load == 4'd0) ? S_XFER : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt <= 4'd1) begin
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = S_XFER;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                S_XFER: begin
                    if (!w_rd && !w_wr) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        w_cs_en = (r_state != S_IDLE) | w_ale;
    end

    assign io_bus.address = w_addr;
    assign io_bus.cs_mem0 = w_sel_mem0 & w_cs_en;
    assign io_bus.cs_mem1 = w_sel_mem1 & w_cs_en;
    assign io_bus.cs_io0  = w_sel_io0 & w_cs_en;
    assign io_bus.cs_io1  = w_sel_io1 & w_cs_en;
    assign io_bus.ready   = (r_state != S_WAIT);

`ifdef BUS_DECODE_ERR_EN
    logic r_bus_err;
    logic w_mapped;
    logic w_err_set;

    assign w_mapped  = w_sel_mem0 | w_sel_mem1 | w_sel_io0 | w_sel_io1;
    assign w_err_set = (r_state == S_ADDR) && !w_ale &&
                       ((w_one_strobe && !w_mapped) || (w_rd && w_wr));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bus_err <= 1'b0;
        end else if (w_err_set) begin
            r_bus_err <= 1'b1;
        end
    end

    assign io_bus.bus_err = r_bus_err;
`else
    assign io_bus.bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_decode_ctrl.sv
// Randomized bench for bus_decode_ctrl: two instances (MEM_WAIT 0 and 3) see the same
// CPU bus activity and are checked against a transaction-level decode/wait model.
module tb_bus_decode_ctrl;

    localparam int MEM_W0 = 0;
    localparam int MEM_W1 = 3;
    localparam int IO_W   = 2;
`ifdef BUS_DECODE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   exp_err  = 1'b0;

    always #5 clk = ~clk;

    bus_decode_ctrl_if u_bus0 ();
    bus_decode_ctrl_if u_bus1 ();

    bus_decode_ctrl #(.MEM_WAIT(MEM_W0), .IO_WAIT(IO_W)) u_dut0 (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(u_bus0)
    );

    bus_decode_ctrl #(.MEM_WAIT(MEM_W1), .IO_WAIT(IO_W)) u_dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(u_bus1)
    );

    logic [3:0] cs0, cs1;
    assign cs0 = {u_bus0.cs_io1, u_bus0.cs_io0, u_bus0.cs_mem1, u_bus0.cs_mem0};
    assign cs1 = {u_bus1.cs_io1, u_bus1.cs_io0, u_bus1.cs_mem1, u_bus1.cs_mem0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {io1, io0, mem1, mem0}
    function automatic logic [3:0] model_cs(input logic [19:0] addr, input logic iom);
        int page;
        if (!iom) return (addr >= 20'h80000) ? 4'b0010 : 4'b0001;
        page = int'(addr[15:0]) / 16;
        if (page == 16'h1C00 / 16) return 4'b0100;
        if (page == 16'hFF00 / 16) return 4'b1000;
        return 4'b0000;
    endfunction

    task automatic drive(input logic ale, input logic rd_n, input logic wr_n,
                         input logic iom, input logic [11:0] a, input logic [7:0] ad);
        u_bus0.ale = ale;  u_bus1.ale = ale;
        u_bus0.rd_n = rd_n; u_bus1.rd_n = rd_n;
        u_bus0.wr_n = wr_n; u_bus1.wr_n = wr_n;
        u_bus0.iom = iom;  u_bus1.iom = iom;
        u_bus0.a = a;      u_bus1.a = a;
        u_bus0.ad = ad;    u_bus1.ad = ad;
    endtask

    task automatic check_pair(input string tag, input logic [19:0] addr,
                              input logic [3:0] cs, input logic rdy);
        check({tag, ".addr0"}, u_bus0.address, addr);
        check({tag, ".addr1"}, u_bus1.address, addr);
        check({tag, ".cs0"}, cs0, cs);
        check({tag, ".cs1"}, cs1, cs);
        check({tag, ".rdy0"}, u_bus0.ready, rdy);
        check({tag, ".rdy1"}, u_bus1.ready, rdy);
    endtask

    // One CPU cycle: ALE, strobe, wait states, optional release back to idle.
    task automatic bus_cycle(input string tag, input logic [19:0] addr, input logic iom,
                             input bit wr, input bit both_first, input bit release_end);
        logic [3:0] ecs;
        int w0, w1, low0, low1, hold;
        ecs  = model_cs(addr, iom);
        w0   = iom ? IO_W : MEM_W0;
        w1   = iom ? IO_W : MEM_W1;
        low0 = 0;
        low1 = 0;

        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b1, iom, addr[19:8], addr[7:0]);
        @(negedge clk);
        check_pair({tag, ".ale"}, addr, ecs, 1'b1);
        check({tag, ".err_pre"}, {u_bus1.bus_err, u_bus0.bus_err}, {2{exp_err}});

        @(posedge clk); #1;
        if (both_first) drive(1'b0, 1'b0, 1'b0, 1'($urandom), 12'($urandom), 8'($urandom));
        else            drive(1'b0, wr, !wr, 1'($urandom), 12'($urandom), 8'($urandom));
        @(negedge clk);
        check_pair({tag, ".addr_st"}, addr, ecs, 1'b1);

        if (both_first) begin
            repeat (2) begin
                @(negedge clk);
                check_pair({tag, ".both"}, addr, ecs, 1'b1);
            end
            if (ERR_EN) exp_err = 1'b1;
            @(posedge clk); #1;
            drive(1'b0, wr, !wr, 1'($urandom), 12'($urandom), 8'($urandom));
            @(negedge clk);
            check({tag, ".both_rdy0"}, u_bus0.ready, 1'b1);
        end

        hold = ((w0 > w1) ? w0 : w1) + 2 + int'($urandom_range(0, 2));
        repeat (hold) begin
            @(negedge clk);
            low0 += (u_bus0.ready == 1'b0) ? 1 : 0;
            low1 += (u_bus1.ready == 1'b0) ? 1 : 0;
            check({tag, ".cs_hold"}, {cs1, cs0}, {ecs, ecs});
        end
        check({tag, ".waits0"}, low0, w0);
        check({tag, ".waits1"}, low1, w1);
        if (ERR_EN && ecs == 4'b0000) exp_err = 1'b1;
        check({tag, ".err"}, {u_bus1.bus_err, u_bus0.bus_err}, {2{exp_err}});

        if (release_end) begin
            @(posedge clk); #1;
            drive(1'b0, 1'b1, 1'b1, 1'($urandom), 12'($urandom), 8'($urandom));
            @(negedge clk);
            check_pair({tag, ".rel"}, addr, ecs, 1'b1);
            @(negedge clk);
            check_pair({tag, ".idle"}, addr, 4'b0000, 1'b1);
        end
    endtask

    initial begin
        logic [19:0] addr;
        logic        iom;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 12'h0, 8'h0);
        #1;
        check_pair("reset", 20'h0, 4'b0000, 1'b1);
        check("reset.err", {u_bus1.bus_err, u_bus0.bus_err}, 2'b00);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        bus_cycle("mem_rd", 20'h12345, 1'b0, 1'b0, 1'b0, 1'b1);
        bus_cycle("io_wr", 20'h01C03, 1'b1, 1'b1, 1'b0, 1'b1);
        bus_cycle("mem_wr", 20'h80010, 1'b0, 1'b1, 1'b0, 1'b1);
        bus_cycle("io_unmap", 20'h02000, 1'b1, 1'b0, 1'b0, 1'b1);
        bus_cycle("io1_rd", 20'h3FF0A, 1'b1, 1'b0, 1'b0, 1'b1);

        // reset pulsed in the middle of the I/O wait states
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 12'h01C, 8'h03);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 12'h0AA, 8'h55);
        @(posedge clk);
        @(negedge clk);
        check("rst_mid.in_wait", u_bus0.ready, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_pair("rst_mid", 20'h0, 4'b0000, 1'b1);
        check("rst_mid.err", {u_bus1.bus_err, u_bus0.bus_err}, 2'b00);
        exp_err = 1'b0;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 12'h0, 8'h0);
        rst = 1'b0;
        @(negedge clk);
        check_pair("rst_after", 20'h0, 4'b0000, 1'b1);
        bus_cycle("post_rst", 20'h01C03, 1'b1, 1'b1, 1'b0, 1'b1);

        // new ALE while still in XFER restarts with a fresh wait count
        bus_cycle("pre_restart", 20'h01C05, 1'b1, 1'b0, 1'b0, 1'b0);
        bus_cycle("restart", 20'h00100, 1'b0, 1'b0, 1'b0, 1'b1);

        bus_cycle("both_low", 20'h01C08, 1'b1, 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: begin iom = 1'b0; addr = 20'($urandom); end
                1: begin iom = 1'b1; addr = {4'($urandom), 12'h1C0, 4'($urandom)}; end
                2: begin iom = 1'b1; addr = {4'($urandom), 12'hFF0, 4'($urandom)}; end
                default: begin iom = 1'b1; addr = 20'($urandom); end
            endcase
            bus_cycle("rand", addr, iom, 1'($urandom), ($urandom_range(0, 7) == 0), 1'b1);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("rand.gap_cs", {cs1, cs0}, 8'h00);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_decode_ctrl.md
BUS_DECODE_CTRL -- requirements
Module: bus_decode_ctrl

Interface
REQ-001 Parameter MEM_WAIT, default 0: wait states inserted on memory cycles (0-15).
REQ-002 Parameter IO_WAIT, default 2: wait states inserted on I/O cycles (0-15).
REQ-003 Parameter IO0_BASE, default 16'h1C00: base of 16-byte I/O region 0.
REQ-004 Parameter IO1_BASE, default 16'hFF00: base of 16-byte I/O region 1.
REQ-005 CLK  in  1  bus clock; all state updates on rising edge.
REQ-006 RESET  in  1  asynchronous, active-high reset.
REQ-007 ALE  in  1  address latch enable from CPU, high during T1.
REQ-008 RD  in  1  read strobe, active low.
REQ-009 WR  in  1  write strobe, active low.
REQ-010 IOM  in  1  1 = I/O cycle, 0 = memory cycle.
REQ-011 A  in  12  upper address bits A[19:8].
REQ-012 AD  in  8  multiplexed address/data bus; address during ALE.
REQ-013 ADDRESS  out  20  demultiplexed address to memory/IO stages.
REQ-014 CS_MEM0, CS_MEM1, CS_IO0, CS_IO1  out  1 each  active-high chip selects.
REQ-015 READY  out  1  to CPU; low inserts a wait state.
REQ-016 BUS_ERR  out  1  sticky unmapped/illegal-access flag (see Configuration).

Function
REQ-017 ADDRESS SHALL be transparent ({A,AD}) while ALE=1 and SHALL hold the value captured on the last cycle ALE was high otherwise; IOM captured alongside.
REQ-018 Decode SHALL be: memory (IOM=0) ADDRESS[19]=0 -> CS_MEM0, =1 -> CS_MEM1; I/O (IOM=1) ADDRESS[15:4]=IO0_BASE[15:4] -> CS_IO0, =IO1_BASE[15:4] -> CS_IO1; anything else unmapped, no CS.
REQ-019 At most one CS SHALL be high in any cycle; CS SHALL be valid combinationally during ALE high and held until the cycle returns to IDLE.
REQ-020 FSM states SHALL be IDLE, ADDR, WAIT, XFER.
REQ-021 IDLE -> ADDR on rising edge with ALE=1; all CS low in IDLE except during ALE.
REQ-022 ADDR: on exactly one of RD/WR low, load wait counter with MEM_WAIT or IO_WAIT per IOM; go XFER if value 0, else WAIT.
REQ-023 WAIT: READY=0, counter decrements each cycle; on reaching 0 go XFER the same edge.
REQ-024 XFER: READY=1; remain until RD=1 and WR=1, then IDLE with CS dropped next cycle.
REQ-025 READY SHALL be 1 in IDLE, ADDR, XFER; 0 only in WAIT; wait-state count equals parameter exactly.
REQ-026 ALE=1 in any non-IDLE state SHALL restart: relatch address, state ADDR, counter cleared.
REQ-027 RD and WR both low in ADDR SHALL be treated as no strobe (stay ADDR) and flagged per REQ-031.
REQ-028 Unmapped cycles SHALL still traverse the FSM with READY handling so the CPU never hangs.

Reset
REQ-029 RESET=1 SHALL immediately force: state IDLE, ADDRESS=20'h0, latched IOM=0, all CS=0, READY=1, counter=0, BUS_ERR=0.
REQ-030 RESET asserted mid-cycle (WAIT/XFER) SHALL abort the cycle; after release the block waits for a new ALE.

Configuration
REQ-031 Macro BUS_DECODE_ERR_EN: when defined, BUS_ERR SHALL set on entry to ADDR->WAIT/XFER with an unmapped address or on RD=WR=0 in ADDR, and SHALL clear only on RESET; when undefined, BUS_ERR SHALL be tied 0 and no error logic compiled.

Verification
REQ-032 Memory read, A=12'h123, AD=8'h45, IOM=0, ALE pulse, RD low -> ADDRESS=20'h12345, CS_MEM0=1, READY never low (MEM_WAIT=0), CS drops one cycle after RD high.
REQ-033 I/O write to 16'h1C03, IOM=1, WR low -> CS_IO0=1, READY low exactly 2 cycles, then high until WR high.
REQ-034 Memory write to 20'h80010 with MEM_WAIT=3 -> CS_MEM1=1, READY low exactly 3 cycles.
REQ-035 I/O read to 16'h2000 with BUS_DECODE_ERR_EN defined -> no CS, READY low 2 cycles, BUS_ERR=1 and held through later valid cycles; undefined -> BUS_ERR=0.
REQ-036 RESET pulsed during WAIT of REQ-033 -> READY=1, CS_IO0=0, ADDRESS=0 immediately; next ALE cycle decodes normally.
REQ-037 Second ALE during XFER with new address 20'h00100 -> ADDRESS updates, state ADDR, CS_MEM0 reflects new address, no wait-state carry-over.
